ddr_rx_deser: RTL and testbench

- Receive-side counterpart of the team's DDR output cell.
- Captures one input pad on both clk edges (rising-edge bit, then falling-edge bit), assembles the bits into W-bit words, and presents them on a valid/ready stream.
- A 2-entry output buffer absorbs backpressure; words that cannot be buffered are dropped and flagged.
- Sits between an off-chip DDR serial source (e.g. DDR SPI/QSPI read lane) and core logic.

---
 rtl/ddr_rx_deser_pkg.sv | 7 +
 rtl/ddr_rx_deser_in.sv | 69 ++++++
 rtl/ddr_rx_deser.sv | 139 +++++++++++++
 tb/tb_ddr_rx_deser.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rx_deser_pkg.sv
// Shared constants for the DDR receive deserialiser.
package ddr_rx_deser_pkg;

    localparam int unsigned FifoDepth = 2;
    localparam int unsigned OccW      = 2;

endpackage

// File: rtl/ddr_rx_deser_in.sv
// Pad capture for the DDR receiver: rise bit on posedge, fall bit on the following negedge,
// plus the sample enable registered alongside the rise bit.
module ddr_in
    import ddr_rx_deser_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pad_i,
    input  logic e_i,
    output logic rise_o,
    output logic fall_o,
    output logic valid_o
);

    logic e_q;

`ifdef FPGA_ICE40
    logic rise_w;
    logic fall_w;

    // Registered DDR input, no output driver.
    SB_IO #(
        .PIN_TYPE (6'b000000),
        .PULLUP   (1'b0)
    ) u_io (
        .PACKAGE_PIN  (pad_i),
        .INPUT_CLK    (clk),
        .CLOCK_ENABLE (1'b1),
        .D_IN_0       (rise_w),
        .D_IN_1       (fall_w)
    );

    assign rise_o = rise_w;
    assign fall_o = fall_w;
`else
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
        end else begin
            rise_q <= pad_i;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= pad_i;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= 1'b0;
        end else begin
            e_q <= e_i;
        end
    end

    assign valid_o = e_q;

endmodule

// File: rtl/ddr_rx_deser.sv
// DDR serial receiver: assembles captured bit pairs into W-bit words and queues them in a
// 2-entry FIFO on a valid/ready stream, flagging words dropped under backpressure.
module ddr_rx_deser
    import ddr_rx_deser_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pad,
    input  logic         e,
    input  logic         align,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overflow,
    input  logic         clr_overflow
);

    localparam int unsigned Pairs = W / 2;
    localparam int unsigned CntW  = (Pairs > 1) ? $clog2(Pairs) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Pairs - 1);

    logic            rise;
    logic            fall;
    logic            pair_vld;
    logic [1:0]      pair;
    logic [W-1:0]    word_msb;
    logic [W-1:0]    word;
    logic            shift_en;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            drop;
    logic            at_last;
    logic            full;

    logic [CntW-1:0] count_q, count_d;
    logic [OccW-1:0] occ_q, occ_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [W-1:0]    mem_q [FifoDepth];
    logic [W-1:0]    mem_d [FifoDepth];
    logic            overflow_q, overflow_d;

    ddr_in u_ddr_in (
        .clk     (clk),
        .rst_n   (rst_n),
        .pad_i   (pad),
        .e_i     (e),
        .rise_o  (rise),
        .fall_o  (fall),
        .valid_o (pair_vld)
    );

    assign pair = {rise, fall};

    // Earliest pair sits at the top of {shreg, pair}; the LSB-first order is its mirror.
    if (W > 2) begin : g_sh
        logic [W-3:0] shreg_q;

        assign word_msb = {shreg_q, pair};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shreg_q <= '0;
            end else if (shift_en) begin
                shreg_q <= word_msb[W-3:0];
            end
        end
    end else begin : g_no_sh
        assign word_msb = pair;
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < int'(W); i++) begin
            word[i] = MSB_FIRST ? word_msb[i] : word_msb[int'(W) - 1 - i];
        end
    end

    always_comb begin
        at_last    = (count_q == LastCnt);
        full       = (occ_q == OccW'(FifoDepth));
        out_valid  = (occ_q != '0);
        pop        = out_valid & out_ready;
        shift_en   = pair_vld & ~align & ~at_last;
        push_req   = pair_vld & ~align & at_last;
        push       = push_req & (~full | pop);
        drop       = push_req & ~push;

        count_d = count_q;
        if (align) begin
            count_d = '0;
        end else if (pair_vld) begin
            count_d = at_last ? '0 : count_q + CntW'(1);
        end

        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q] = word;
        end
        wr_d = wr_q ^ push;
        rd_d = rd_q ^ pop;

        // A drop on the same edge as a clear leaves the flag set.
        overflow_d = drop | (overflow_q & ~clr_overflow);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            occ_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            mem_q      <= '{default: '0};
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            occ_q      <= occ_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            mem_q      <= mem_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_data = mem_q[rd_q];
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ddr_rx_deser.sv
// Randomised scoreboard bench for ddr_rx_deser: MSB-first and LSB-first instances share stimulus.
module tb_ddr_rx_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pad = 1'b0;
    logic         e = 1'b0;
    logic         align = 1'b0;
    logic         out_ready = 1'b0;
    logic         clr_overflow = 1'b0;
    logic [W-1:0] dm, dl;
    logic         vm, vl, om, ol;

    always #5 clk = ~clk;

    ddr_rx_deser #(.W(W), .MSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pad          (pad),
        .e            (e),
        .align        (align),
        .out_data     (dm),
        .out_valid    (vm),
        .out_ready    (out_ready),
        .overflow     (om),
        .clr_overflow (clr_overflow)
    );

    ddr_rx_deser #(.W(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk          (clk),
        .rst_n        (rst_n),
        .pad          (pad),
        .e            (e),
        .align        (align),
        .out_data     (dl),
        .out_valid    (vl),
        .out_ready    (out_ready),
        .overflow     (ol),
        .clr_overflow (clr_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect received bits into a list, emit a word when W bits are present,
    // and keep a buffered-word count bounded at two.
    logic         pm_r, pm_f, pm_e;
    logic         bits_q[$];
    logic [W-1:0] exp_m[$];
    logic [W-1:0] exp_l[$];
    int           occ;
    logic         ovf;

    always @(posedge clk or negedge rst_n) begin
        logic         have;
        logic [W-1:0] wm, wl;
        if (!rst_n) begin
            bits_q.delete();
            exp_m.delete();
            exp_l.delete();
            occ  = 0;
            ovf  = 1'b0;
            pm_r = 1'b0;
            pm_e = 1'b0;
        end else begin
            have = 1'b0;
            wm   = '0;
            wl   = '0;
            if (align) begin
                bits_q.delete();
            end else if (pm_e) begin
                bits_q.push_back(pm_r);
                bits_q.push_back(pm_f);
                if (bits_q.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        wm[W-1-i] = bits_q[i];
                        wl[i]     = bits_q[i];
                    end
                    have = 1'b1;
                    bits_q.delete();
                end
            end
            if (occ > 0 && out_ready) occ--;
            if (have && occ < 2) begin
                occ++;
                exp_m.push_back(wm);
                exp_l.push_back(wl);
                if (clr_overflow) ovf = 1'b0;
            end else if (have) begin
                ovf = 1'b1;
            end else if (clr_overflow) begin
                ovf = 1'b0;
            end
            pm_r = pad;
            pm_e = e;
        end
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) pm_f = 1'b0;
        else        pm_f = pad;
    end

    // Monitor: samples 1 time unit before each posedge.
    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            check("valid_msb", {31'b0, vm}, {31'b0, occ > 0});
            check("valid_lsb", {31'b0, vl}, {31'b0, occ > 0});
            check("overflow_msb", {31'b0, om}, {31'b0, ovf});
            check("overflow_lsb", {31'b0, ol}, {31'b0, ovf});
            if (vm) begin
                if (exp_m.size() == 0 || exp_l.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected none", dm);
                end else begin
                    check("data_msb", {24'b0, dm}, {24'b0, exp_m[0]});
                    check("data_lsb", {24'b0, dl}, {24'b0, exp_l[0]});
                    if (out_ready) begin
                        void'(exp_m.pop_front());
                        void'(exp_l.pop_front());
                    end
                end
            end
        end
    end

    logic al_v = 1'b0;
    logic rdy_v = 1'b0;
    logic clr_v = 1'b0;

    // One clk cycle: rise bit and controls before posedge, fall bit before negedge.
    task automatic drive(input logic r, input logic f, input logic ev);
        @(negedge clk);
        #3;
        pad          = r;
        e            = ev;
        align        = al_v;
        out_ready    = rdy_v;
        clr_overflow = clr_v;
        al_v         = 1'b0;
        clr_v        = 1'b0;
        @(posedge clk);
        #3;
        pad = f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_pairs(input logic [W-1:0] w, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) drive(w[W-1-2*k], w[W-2-2*k], 1'b1);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        send_pairs(w, 0, W/2 - 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'b0, vm}, 32'd0);
        check("reset_overflow", {31'b0, om}, 32'd0);
        check("reset_data", {24'b0, dm}, 32'd0);
        #2 rst_n = 1'b1;

        rdy_v = 1'b1;
        send_word(8'hB2);
        idle(4);

        send_pairs(8'hB2, 0, 1);
        idle(3);
        send_pairs(8'hB2, 2, 3);
        idle(4);

        rdy_v = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        idle(2);
        check("overflow_after_third", {31'b0, om}, 32'd1);
        rdy_v = 1'b1;
        idle(4);
        clr_v = 1'b1;
        idle(2);
        check("overflow_cleared", {31'b0, om}, 32'd0);

        send_pairs(8'hFF, 0, 2);
        al_v = 1'b1;
        send_word(8'hA5);
        idle(4);

        send_word(8'h77);
        al_v = 1'b1;
        idle(4);

        rdy_v = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h44);
        rdy_v = 1'b1;
        idle(6);

        rdy_v = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_pairs(8'h55, 0, 1);
        e = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", {31'b0, vm}, 32'd0);
        check("async_reset_overflow", {31'b0, om}, 32'd0);
        check("async_reset_lsb_valid", {31'b0, vl}, 32'd0);
        #10 rst_n = 1'b1;
        rdy_v = 1'b1;
        send_word(8'h3C);
        idle(4);

        for (int i = 0; i < 1500; i++) begin
            al_v  = ($urandom % 32) == 0;
            clr_v = ($urandom % 20) == 0;
            rdy_v = ($urandom % 10) < 6;
            drive(1'($urandom), 1'($urandom), ($urandom % 10) < 7);
        end

        al_v  = 1'b0;
        rdy_v = 1'b1;
        idle(6);
        check("drained", exp_m.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
